// File: rtl/posit32_regime_arbiter_pkg.sv
// Shared posit32 types and constants for the regime-decode arbiter slice.
package posit_types;
    localparam int POSIT32_RUN_W = 5;
    localparam logic [31:0] POSIT32_ZERO = 32'h0000_0000;
    localparam logic [31:0] POSIT32_NAR  = 32'h8000_0000;

    typedef logic [31:0] posit32_t;

    typedef struct packed {
        logic                     sign;
        logic                     special;
        logic [POSIT32_RUN_W-1:0] run;
        logic signed [5:0]        k;
    } posit32_regime_t;
endpackage

// File: rtl/posit32_regime_arbiter_if.sv
// Request and result handshake bundle between issue queues, the arbiter and the extract stage.
interface posit32_regime_arbiter_if
    import posit_types::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) ();
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0][31:0] req_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [ID_W-1:0]          out_id;
    posit32_t                 out_data;
    posit32_regime_t          out_regime;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_id, out_data, out_regime
    );
    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_id, out_data, out_regime
    );
endinterface

// File: rtl/posit32_regime_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches from the last winner + 1 with wrap-around; owns the pointer.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);
    logic [IW-1:0] last;

    always_comb begin
        int  j;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int off = 1; off <= N; off++) begin
            j = int'(last) + off;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
            end
        end
    end

    // Pointer moves only on an accepted transfer, so an idle grant can wander freely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          last <= IW'(N - 1);
        else if (advance) last <= grant_idx;
    end
endmodule

// File: rtl/posit32_regime_arbiter.sv
// Shared posit32 regime decoder: round-robin select, operand register, result register.
// Optional per-requester grant counters under POSIT32_ARB_STATS_EN.
module posit32_regime_arbiter
    import posit_types::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    posit32_regime_arbiter_if.slave  bus
`ifdef POSIT32_ARB_STATS_EN
    ,
    input  logic                     stat_clr,
    output logic [NUM_REQ-1:0][15:0] stat_grants
`endif
);
    function automatic posit32_regime_t regime_of(input posit32_t d);
        posit32_regime_t r;
        logic [30:0]     body;
        logic            stop;
        r      = '0;
        r.sign = d[31];
        stop   = 1'b0;
        // Low 31 bits of the two's complement are all the run scan needs.
        body   = d[31] ? 31'(~d[30:0] + 31'd1) : d[30:0];
        if (d == POSIT32_ZERO || d == POSIT32_NAR) begin
            r.special = 1'b1;
        end else begin
            for (int i = 30; i >= 0; i--) begin
                if (!stop) begin
                    if (body[i] == body[30]) r.run = r.run + 1'b1;
                    else                     stop  = 1'b1;
                end
            end
            r.k = body[30] ? $signed({1'b0, r.run}) - 6'sd1 : -$signed({1'b0, r.run});
        end
        return r;
    endfunction

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [2:1]         vld_pipe;
    logic [ID_W-1:0]    s1_id;
    posit32_t           s1_data;
    logic [ID_W-1:0]    out_id_q;
    posit32_t           out_data_q;
    posit32_regime_t    out_regime_q;
    logic               s1_ready, s2_ready, any_req, accept;

    assign any_req  = |bus.req_valid;
    assign s2_ready = !vld_pipe[2] | bus.out_ready;
    assign s1_ready = !vld_pipe[1] | s2_ready;
    assign accept   = any_req & s1_ready;

    rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign bus.req_ready  = grant & {NUM_REQ{s1_ready}};
    assign bus.out_valid  = vld_pipe[2];
    assign bus.out_id     = out_id_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_regime = out_regime_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe     <= '0;
            s1_id        <= '0;
            s1_data      <= '0;
            out_id_q     <= '0;
            out_data_q   <= '0;
            out_regime_q <= '0;
        end else begin
            if (s1_ready) begin
                vld_pipe[1] <= any_req;
                if (any_req) begin
                    s1_id   <= grant_idx;
                    s1_data <= bus.req_data[grant_idx];
                end
            end
            if (s2_ready) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    out_id_q     <= s1_id;
                    out_data_q   <= s1_data;
                    out_regime_q <= regime_of(s1_data);
                end
            end
        end
    end

`ifdef POSIT32_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_grants <= '0;
        end else if (stat_clr) begin
            stat_grants <= '0;
        end else begin
            for (int g = 0; g < NUM_REQ; g++) begin
                if (accept && grant_idx == ID_W'(g) && stat_grants[g] != 16'hFFFF)
                    stat_grants[g] <= stat_grants[g] + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_posit32_regime_arbiter.sv
// Directed + random bench for posit32_regime_arbiter against an arithmetic reference model.
module tb_posit32_regime_arbiter;
    import posit_types::*;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    posit32_regime_arbiter_if #(.NUM_REQ(N)) bus ();
`ifdef POSIT32_ARB_STATS_EN
    logic             stat_clr;
    logic [N-1:0][15:0] stat_grants;
`endif

    posit32_regime_arbiter #(.NUM_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef POSIT32_ARB_STATS_EN
        ,
        .stat_clr    (stat_clr),
        .stat_grants (stat_grants)
`endif
    );

    typedef struct { int id; logic [31:0] data; } item_t;
    item_t expq[$];

    int tests = 0, fails = 0, cyc = 0;
    int n_acc = 0, n_out = 0, acc_cyc = 0, out_cyc = 0, m_last = N - 1, last_acc_id = -1;
    int refill = 0;     // 0 none, 1 every idle requester, 2 random
    int ordy_mode = 1;  // 0 low, 1 high, 2 random
    int cnt_model[N];
    logic [N-1:0] pend_v;
    logic [31:0]  pend_d[N];
    logic [12:0]  last_reg;
    logic         prv_stall;
    logic [47:0]  prv_snap;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int flog2(input longint x);
        return $clog2(x + 1) - 1;
    endfunction

    // Regime from the numeric value: leading run length via floor(log2) of the body.
    function automatic logic [12:0] ref_regime(input logic [31:0] d);
        longint mag, body, inv;
        int run, k;
        logic [4:0] r5;
        logic [5:0] k6;
        if (d == 32'h0 || d == 32'h8000_0000) return {d[31], 1'b1, 11'd0};
        mag = d;
        if (d[31]) mag = 64'sh1_0000_0000 - mag;
        body = mag & 64'h7FFF_FFFF;
        if (body >= 64'h4000_0000) begin
            inv = 64'h7FFF_FFFF - body;
            run = (inv == 0) ? 31 : 30 - flog2(inv);
            k   = run - 1;
        end else begin
            run = 30 - flog2(body);
            k   = -run;
        end
        r5 = 5'(run);
        k6 = 6'(k);
        return {d[31], 1'b0, r5, k6};
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int o = 1; o <= N; o++)
            if (v[(last + o) % N]) return (last + o) % N;
        return -1;
    endfunction

    function automatic logic [31:0] rand_posit();
        logic [31:0] one;
        one = 32'd1;
        case ($urandom_range(7, 0))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return one << $urandom_range(31, 0);
            4:       return ~(one << $urandom_range(31, 0));
            default: return $urandom;
        endcase
    endfunction

    task automatic check_cycle();
        logic [47:0] snap;
        item_t it;
        int idx;
        snap = {bus.out_valid, bus.out_id, bus.out_data, bus.out_regime};
        if (prv_stall) chk("hold_stable", snap, prv_snap);
        if (bus.out_valid && bus.out_ready) begin
            chk("out_pending", expq.size() > 0, 1);
            if (expq.size() > 0) begin
                it = expq.pop_front();
                chk("out_id", bus.out_id, it.id);
                chk("out_data", bus.out_data, it.data);
                chk("out_regime", bus.out_regime, ref_regime(it.data));
                last_reg = bus.out_regime;
                n_out++;
                out_cyc = cyc;
            end
        end
        if (bus.req_ready != '0) begin
            chk("ready_onehot", $onehot(bus.req_ready), 1);
            idx = $clog2(bus.req_ready);
            chk("rr_grant", idx, rr_pick(pend_v, m_last));
            expq.push_back('{id: idx, data: pend_d[idx]});
            m_last = idx;
            last_acc_id = idx;
            pend_v[idx] = 1'b0;
            cnt_model[idx]++;
            n_acc++;
            acc_cyc = cyc;
        end
        prv_stall = bus.out_valid && !bus.out_ready;
        prv_snap  = snap;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (!pend_v[i] && (refill == 1 || (refill == 2 && $urandom_range(1, 0) == 1))) begin
                pend_v[i] = 1'b1;
                pend_d[i] = rand_posit();
            end
        end
        bus.req_valid = pend_v;
        for (int i = 0; i < N; i++) bus.req_data[i] = pend_d[i];
        bus.out_ready = (ordy_mode == 0) ? 1'b0 : (ordy_mode == 1) ? 1'b1 : ($urandom_range(3, 0) != 0);
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    logic [31:0] dir_data[6] = '{32'h4000_0000, 32'h7FFF_FFFF, 32'h0000_0001,
                                 32'hC000_0000, 32'h0000_0000, 32'h8000_0000};
    // {sign, special, run, k}
    logic [12:0] dir_exp[6] = '{{1'b0, 1'b0, 5'd1,  6'd0},
                                {1'b0, 1'b0, 5'd31, 6'd30},
                                {1'b0, 1'b0, 5'd30, 6'h22},
                                {1'b1, 1'b0, 5'd1,  6'd0},
                                {1'b0, 1'b1, 5'd0,  6'd0},
                                {1'b1, 1'b1, 5'd0,  6'd0}};

    initial begin
        int a0, o0;
        rst = 1'b1;
        pend_v = '0;
        for (int i = 0; i < N; i++) begin pend_d[i] = '0; cnt_model[i] = 0; end
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
        prv_stall = 1'b0;
        prv_snap  = '0;
        last_reg  = '0;
`ifdef POSIT32_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_id", bus.out_id, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_regime", bus.out_regime, 0);
        chk("rst_req_ready", bus.req_ready, 0);
`ifdef POSIT32_ARB_STATS_EN
        chk("rst_stats", stat_grants, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();

        // Directed regime vectors through requester 0, with latency check.
        for (int v = 0; v < 6; v++) begin
            pend_v[0] = 1'b1;
            pend_d[0] = dir_data[v];
            drive();
            repeat (5) step();
            chk($sformatf("dir_regime_%0d", v), last_reg, dir_exp[v]);
            chk($sformatf("latency_%0d", v), out_cyc - acc_cyc, 2);
        end

        // All requesters valid, out_ready high: one accept and one result per cycle.
        refill = 1;
        drive();
        a0 = n_acc; o0 = n_out;
        repeat (12) step();
        chk("cont_accepts", n_acc - a0, 12);
        chk("cont_outputs", n_out - o0, 10);
        refill = 0;
        repeat (6) step();
        chk("cont_drain", expq.size(), 0);

        // Output stall with everyone requesting: two accepts fill the pipe, then nothing.
        refill = 1; ordy_mode = 0;
        drive();
        a0 = n_acc; o0 = n_out;
        repeat (5) step();
        chk("stall_accepts", n_acc - a0, 2);
        chk("stall_ready_zero", bus.req_ready, 0);
        refill = 0; ordy_mode = 1;
        drive();
        repeat (10) step();
        chk("stall_drain", expq.size(), 0);
        chk("stall_no_loss", n_out - o0, n_acc - a0);

        // Random traffic and random backpressure.
        refill = 2; ordy_mode = 2;
        drive();
        repeat (400) step();
        refill = 0; ordy_mode = 1;
        drive();
        repeat (12) step();
        chk("rand_drain", expq.size(), 0);
        chk("rand_pending", pend_v, 0);

        // Reset with both stages full.
        refill = 1; ordy_mode = 0;
        drive();
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("rst_async_valid", bus.out_valid, 0);
        refill = 0; ordy_mode = 1;
        pend_v = '0;
        expq.delete();
        m_last = N - 1;
        prv_stall = 1'b0;
        for (int i = 0; i < N; i++) cnt_model[i] = 0;
        drive();
        repeat (2) @(posedge clk);
        #1;
`ifdef POSIT32_ARB_STATS_EN
        chk("rst_mid_stats", stat_grants, 0);
`endif
        rst = 1'b0;
        pend_v = '1;
        for (int i = 0; i < N; i++) pend_d[i] = rand_posit();
        drive();
        step();
        chk("rst_first_grant", last_acc_id, 0);
        repeat (8) step();
        chk("rst_drain", expq.size(), 0);
`ifdef POSIT32_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk($sformatf("stat_%0d", i), stat_grants[i], cnt_model[i]);
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        chk("stat_clr", stat_grants, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
